// File: rtl/interp_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : interp_block_buffer
// Description : Two-bank ping-pong buffer that collects 4-row interpolated
//               blocks and streams whole blocks out under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module interp_block_buffer (
    input  logic        CLK,
    input  logic        RESET_ALL,
    input  logic        IN_VALID,
    input  logic [13:0] IN_SAMPLE_0,
    input  logic [13:0] IN_SAMPLE_1,
    input  logic [13:0] IN_SAMPLE_2,
    input  logic [13:0] IN_SAMPLE_3,
    input  logic        OUT_READY,
    output logic        OUT_VALID,
    output logic [55:0] OUT_ROW,
    output logic [1:0]  OUT_ROW_IDX,
    output logic        OUT_LAST,
    output logic        OVERFLOW,
    output logic [7:0]  BLOCK_COUNT
);

    localparam logic [1:0] c_LAST_ROW = 2'd3;

    logic [55:0] r_mem [0:7];
    logic        r_wr_bank;
    logic [1:0]  r_wr_row;
    logic        r_rd_bank;
    logic [1:0]  r_rd_row;
    logic [1:0]  r_full;
    logic        r_overflow;
    logic [7:0]  r_block_count;

    logic w_wr_en;
    logic w_wr_drop;
    logic w_rd_xfer;

    // Both sides look at FULL as it stood before the edge, so a write into the
    // bank being freed on this same edge is still treated as a collision.
    assign w_wr_en   = IN_VALID && !r_full[r_wr_bank] && !RESET_ALL;
    assign w_wr_drop = IN_VALID &&  r_full[r_wr_bank] && !RESET_ALL;
    assign w_rd_xfer = r_full[r_rd_bank] && OUT_READY;

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_row}] <= {IN_SAMPLE_3, IN_SAMPLE_2, IN_SAMPLE_1, IN_SAMPLE_0};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_ALL) begin
            r_wr_bank     <= 1'b0;
            r_wr_row      <= 2'd0;
            r_rd_bank     <= 1'b0;
            r_rd_row      <= 2'd0;
            r_full        <= 2'b00;
            r_overflow    <= 1'b0;
            r_block_count <= 8'd0;
        end else begin
            if (w_wr_en) begin
                r_wr_row <= r_wr_row + 2'd1;
                if (r_wr_row == c_LAST_ROW) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            // A write only targets an empty bank and a read only a full one,
            // so the two FULL updates never hit the same bit.
            if (w_rd_xfer) begin
                r_rd_row <= r_rd_row + 2'd1;
                if (r_rd_row == c_LAST_ROW) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_block_count     <= r_block_count + 8'd1;
                end
            end
        end
    end

    assign OUT_VALID   = r_full[r_rd_bank];
    assign OUT_ROW     = r_mem[{r_rd_bank, r_rd_row}];
    assign OUT_ROW_IDX = r_rd_row;
    assign OUT_LAST    = OUT_VALID && (r_rd_row == c_LAST_ROW);
    assign OVERFLOW    = r_overflow;
    assign BLOCK_COUNT = r_block_count;

endmodule
`default_nettype wire

// File: tb/tb_interp_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interp_block_buffer
// Description : Self-checking bench for interp_block_buffer (vector table plus
//               hand-written corner sequences, queue-based output scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_block_buffer;

    logic        CLK = 1'b0;
    logic        RESET_ALL = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [13:0] IN_SAMPLE_0 = '0;
    logic [13:0] IN_SAMPLE_1 = '0;
    logic [13:0] IN_SAMPLE_2 = '0;
    logic [13:0] IN_SAMPLE_3 = '0;
    logic        OUT_READY = 1'b0;
    logic        OUT_VALID;
    logic [55:0] OUT_ROW;
    logic [1:0]  OUT_ROW_IDX;
    logic        OUT_LAST;
    logic        OVERFLOW;
    logic [7:0]  BLOCK_COUNT;

    interp_block_buffer dut (
        .CLK(CLK), .RESET_ALL(RESET_ALL), .IN_VALID(IN_VALID),
        .IN_SAMPLE_0(IN_SAMPLE_0), .IN_SAMPLE_1(IN_SAMPLE_1),
        .IN_SAMPLE_2(IN_SAMPLE_2), .IN_SAMPLE_3(IN_SAMPLE_3),
        .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_ROW(OUT_ROW),
        .OUT_ROW_IDX(OUT_ROW_IDX), .OUT_LAST(OUT_LAST), .OVERFLOW(OVERFLOW),
        .BLOCK_COUNT(BLOCK_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    n_rows;   // IN_VALID pulses, back to back
        int    stall;    // cycles OUT_READY stays low after writing (0 = ready throughout)
        int    keep;     // rows expected to survive
        bit    ovf;
        int    blocks;
    } vec_t;

    typedef struct packed {
        logic [55:0] row;
        logic [1:0]  idx;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard: every transfer seen on the output is matched against the queue.
    always @(negedge CLK) begin
        if (!RESET_ALL && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_row: got row 0x%0h idx %0d, expected no transfer", OUT_ROW, OUT_ROW_IDX);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_row", 64'(OUT_ROW), 64'(e.row));
                chk("out_row_idx", 64'(OUT_ROW_IDX), 64'(e.idx));
                chk("out_last", 64'(OUT_LAST), 64'(e.idx == 2'd3));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_ALL = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        tick();
        RESET_ALL = 1'b0;
    endtask

    task automatic send(int n, int base, int keep);
        for (int r = 0; r < n; r++) begin
            logic [13:0] s0, s1, s2, s3;
            s0 = 14'(base + r*4 + 0);
            s1 = 14'(base + r*4 + 1);
            s2 = 14'(base + r*4 + 2);
            s3 = 14'(base + r*4 + 3);
            IN_SAMPLE_0 = s0;
            IN_SAMPLE_1 = s1;
            IN_SAMPLE_2 = s2;
            IN_SAMPLE_3 = s3;
            IN_VALID    = 1'b1;
            if (r < keep) q.push_back('{row: {s3, s2, s1, s0}, idx: 2'(r % 4)});
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain(string name);
        OUT_READY = 1'b1;
        for (int c = 0; c < 3000 && q.size() != 0; c++) tick();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout: got %0d rows left, expected 0", name, q.size());
        end
        q.delete();
        repeat (3) tick();
        chk({name, "_idle_valid"}, 64'(OUT_VALID), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"single",      4,  0, 4,  1'b0, 1};
        vecs[1] = '{"backpress",   4,  5, 4,  1'b0, 1};
        vecs[2] = '{"overflow",    9,  3, 8,  1'b1, 2};
        vecs[3] = '{"pingpong",    16, 0, 16, 1'b0, 4};
        vecs[4] = '{"partial",     3,  0, 0,  1'b0, 0};
        vecs[5] = '{"two_blocks",  8,  0, 8,  1'b0, 2};

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_row_idx", 64'(OUT_ROW_IDX), 64'd0);
        chk("rst_out_last", 64'(OUT_LAST), 64'd0);
        chk("rst_overflow", 64'(OVERFLOW), 64'd0);
        chk("rst_block_count", 64'(BLOCK_COUNT), 64'd0);

        // Block-level vectors
        for (int v = 0; v < 6; v++) begin
            do_reset();
            OUT_READY = (vecs[v].stall == 0);
            send(vecs[v].n_rows, v * 100, vecs[v].keep);
            chk({vecs[v].name, "_ovf_write"}, 64'(OVERFLOW), 64'(vecs[v].ovf));
            if (vecs[v].stall > 0) begin
                logic [55:0] held_row;
                logic [1:0]  held_idx;
                held_row = OUT_ROW;
                held_idx = OUT_ROW_IDX;
                chk({vecs[v].name, "_stall_valid"}, 64'(OUT_VALID), 64'd1);
                for (int c = 0; c < vecs[v].stall; c++) begin
                    tick();
                    chk({vecs[v].name, "_stall_row"}, 64'(OUT_ROW), 64'(held_row));
                    chk({vecs[v].name, "_stall_idx"}, 64'(OUT_ROW_IDX), 64'(held_idx));
                end
            end
            drain(vecs[v].name);
            chk({vecs[v].name, "_ovf_end"}, 64'(OVERFLOW), 64'(vecs[v].ovf));
            chk({vecs[v].name, "_blocks"}, 64'(BLOCK_COUNT), 64'(vecs[v].blocks));
        end

        // Reset mid-block: IN_VALID during reset is ignored, only new rows appear
        do_reset();
        OUT_READY = 1'b1;
        send(2, 500, 0);
        RESET_ALL = 1'b1;
        IN_VALID  = 1'b1;
        tick();
        RESET_ALL = 1'b0;
        IN_VALID  = 1'b0;
        chk("midrst_row_idx", 64'(OUT_ROW_IDX), 64'd0);
        OUT_READY = 1'b1;
        send(4, 600, 4);
        drain("midrst");
        chk("midrst_blocks", 64'(BLOCK_COUNT), 64'd1);
        chk("midrst_ovf", 64'(OVERFLOW), 64'd0);

        // Write into the bank being freed on the same edge is dropped
        do_reset();
        send(8, 700, 8);
        chk("collide_valid", 64'(OUT_VALID), 64'd1);
        chk("collide_ovf_before", 64'(OVERFLOW), 64'd0);
        OUT_READY = 1'b1;
        repeat (3) tick();
        chk("collide_last", 64'(OUT_LAST), 64'd1);
        IN_SAMPLE_0 = 14'h3fff;
        IN_VALID    = 1'b1;
        tick();
        IN_VALID    = 1'b0;
        chk("collide_ovf", 64'(OVERFLOW), 64'd1);
        drain("collide");
        chk("collide_blocks", 64'(BLOCK_COUNT), 64'd2);

        // Block counter wraps after 256 drained blocks
        do_reset();
        OUT_READY = 1'b1;
        send(1020, 0, 1020);
        for (int c = 0; c < 20 && q.size() != 0; c++) tick();
        chk("wrap_count_255", 64'(BLOCK_COUNT), 64'd255);
        send(4, 50, 4);
        drain("wrap");
        chk("wrap_count_0", 64'(BLOCK_COUNT), 64'd0);
        chk("wrap_ovf", 64'(OVERFLOW), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
